seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, next generation of the team's single-bit half/full adder cells. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock using a start/busy/done handshake, and reports carry-out and signed overflow. It serves as the shared arithmetic unit in lab datapaths where area matters more than single-cycle latency.

---
 rtl/seq_chunk_adder.sv | 144 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor.
// Processes CHUNK bits per clock through a ripple slice. Results are
// published on the last RUN edge and held until the next completion.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0]       chunk_sum;
    logic                   chunk_cout;
    logic                   chunk_cmsb;   // carry into the top bit of this slice
    logic [WIDTH+CHUNK-1:0] res_cat;
    logic [WIDTH-1:0]       res_shift;

    // Ripple slice over the low CHUNK bits of the operand shift registers.
    always_comb begin
        logic c;
        c          = carry_q;
        chunk_sum  = '0;
        chunk_cmsb = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                chunk_cmsb = c;
            end
            chunk_sum[i] = a_q[i] ^ b_q[i] ^ c;
            c            = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        chunk_cout = c;
    end

    // New slice bits enter at the top of the result shift register.
    always_comb begin
        res_cat   = {chunk_sum, res_q};
        res_shift = res_cat[WIDTH+CHUNK-1:CHUNK];
    end

    // Control and datapath next-state; DONE accepts start like IDLE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtraction runs as a + ~b + ~cin.
                    a_d     = a;
                    b_d     = mode ? ~b : b;
                    carry_d = mode ? ~cin : cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d   = res_shift;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = chunk_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // This slice holds bit WIDTH-1, so its internal carry
                    // is the carry into the MSB used for overflow.
                    sum_d   = res_shift;
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_cmsb ^ chunk_cout;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: three instances (CHUNK=2,1,8) share operand
// inputs and reset, each with its own start; results checked against a
// vector table, hand sequences and an arithmetic reference model.
module tb_seq_chunk_adder;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic [7:0] a, b;
    logic       cin;
    logic       start_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] sum_v   [3];
    logic       cout_v  [3];
    logic       ovf_v   [3];

    int errors = 0;
    int checks = 0;
    int lat_n [3] = '{4, 8, 1};
    int chunk_of [3] = '{2, 1, 8};

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] av;
        logic [7:0] bv;
        logic       m;
        logic       c;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic m, input logic c,
                         output logic [7:0] s, output logic co, output logic ov);
        int u, si;
        if (!m) begin
            u  = int'(av) + int'(bv) + int'(c);
            si = int'($signed(av)) + int'($signed(bv)) + int'(c);
            co = (u > 255);
        end else begin
            u  = int'(av) - int'(bv) - int'(c);
            si = int'($signed(av)) - int'($signed(bv)) - int'(c);
            co = (u >= 0);
        end
        s  = u[7:0];
        ov = (si > 127) || (si < -128);
    endtask

    // Called at a negedge: present operands with start, hold through one edge,
    // then scramble the inputs to prove they are not re-sampled.
    task automatic start_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                            input logic m, input logic c);
        a = av; b = bv; mode = m; cin = c;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        mode = 1'($urandom); cin = 1'($urandom);
    endtask

    // Samples on negedges until done; returns at the negedge of the done cycle.
    task automatic wait_check(input int k, input logic [7:0] es, input logic ec, input logic eo,
                              input string nm);
        int   at;
        bit   both;
        bit   held;
        logic [7:0] hold;
        at = 0; both = 0; held = 1; hold = sum_v[k];
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy_v[k] && done_v[k]) both = 1;
            if (done_v[k]) begin
                at = i;
                break;
            end
            if (!busy_v[k]) both = 1;
            if (sum_v[k] !== hold) held = 0;
        end
        if (at == 0) begin
            errors++; checks++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", nm);
            return;
        end
        chk({nm, "_latency"}, at, lat_n[k] + 1);
        chk({nm, "_busy_excl"}, {31'd0, both}, 0);
        chk({nm, "_hold"}, {31'd0, held}, 1);
        chk({nm, "_sum"}, {24'd0, sum_v[k]}, {24'd0, es});
        chk({nm, "_cout"}, {31'd0, cout_v[k]}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ovf_v[k]}, {31'd0, eo});
        $display("op %s chunk=%0d sum=%02h cout=%0b ovf=%0b exp=%02h/%0b/%0b lat=%0d",
                 nm, chunk_of[k], sum_v[k], cout_v[k], ovf_v[k], es, ec, eo, at);
    endtask

    initial begin
        logic [7:0] es, av, bv;
        logic       ec, eo, m, c;
        int         ndone;
        logic [7:0] seen_sum;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};

        rst_n = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy%0d", k), {31'd0, busy_v[k]}, 0);
            chk($sformatf("reset_done%0d", k), {31'd0, done_v[k]}, 0);
            chk($sformatf("reset_out%0d", k), {22'd0, sum_v[k], cout_v[k], ovf_v[k]}, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back on each instance.
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 4; v++) begin
                start_op(k, tbl[v].av, tbl[v].bv, tbl[v].m, tbl[v].c);
                wait_check(k, tbl[v].es, tbl[v].ec, tbl[v].eo, $sformatf("tbl%0d_k%0d", v, k));
            end
            @(negedge clk);
        end

        // start pulsed and operands changed during RUN: one done, original result.
        start_op(0, 8'h33, 8'h44, 1'b0, 1'b0);
        ndone = 0; seen_sum = 8'h00;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) begin start_v[0] = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (i == 3) start_v[0] = 1'b0;
            if (done_v[0]) begin ndone++; seen_sum = sum_v[0]; end
        end
        chk("run_start_ndone", ndone, 1);
        chk("run_start_sum", {24'd0, seen_sum}, 32'h77);
        $display("op run_start chunk=2 dones=%0d sum=%02h", ndone, seen_sum);

        // Reset in RUN cycle 2 aborts and clears outputs immediately.
        start_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy_v[0]}, 0);
        chk("abort_done", {31'd0, done_v[0]}, 0);
        chk("abort_out", {22'd0, sum_v[0], cout_v[0], ovf_v[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) ndone++;
        end
        chk("abort_quiet", ndone, 0);
        chk("abort_sum_held", {24'd0, sum_v[0]}, 0);
        $display("op abort chunk=2 activity=%0d sum=%02h", ndone, sum_v[0]);
        start_op(0, 8'h01, 8'h01, 1'b0, 1'b0);
        wait_check(0, 8'h02, 1'b0, 1'b0, "post_reset");

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            int k;
            k  = int'($urandom_range(0, 2));
            av = 8'($urandom); bv = 8'($urandom);
            m  = 1'($urandom); c = 1'($urandom);
            model(av, bv, m, c, es, ec, eo);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
            start_op(k, av, bv, m, c);
            wait_check(k, es, ec, eo, $sformatf("rnd%0d_%s_%02h_%02h_%0b", n, m ? "sub" : "add", av, bv, c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
